// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//
// Shared definitions for the 4-bit Gray bus: the transmitter (gray_emisor)
// and the reader/decoder side both import this package so that the encode
// and decode rules live in exactly one place.
//
// Contents:
//   GRAY_WIDTH  default bus/counter width
//   GRAY_MAX_W  widest word the helper functions handle
//   state_e     transmitter FSM states (IDLE, WAIT, PRESENT)
//   bin2gray    binary -> Gray (b ^ (b >> 1))
//   gray2bin    Gray -> binary (prefix XOR from the MSB down)
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int unsigned GRAY_WIDTH = 4;

    // The helpers work on a fixed wide word; callers zero-extend their
    // operand and keep the low WIDTH bits of the result. Leading zeros are
    // neutral for both directions of the conversion.
    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // nothing presented, not counting
        WAIT    = 2'd1,  // auto mode, step timer running, valid low
        PRESENT = 2'd2   // word on the bus, waiting for ack
    } state_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg

// File: rtl/gray_paso_timer.sv
// -----------------------------------------------------------------------------
// gray_paso_timer
//
// Step timer for the auto-count mode of gray_emisor. Counts enabled cycles
// from 0 up to STEP_DIV-1 and raises a terminal-count pulse on the cycle it
// sits at STEP_DIV-1; on that same edge it wraps back to 0. A clear forces
// the count to 0 and has priority over the enable.
//
// Ports:
//   reloj  in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en_i   in   count this cycle
//   clr_i  in   synchronous clear to 0 (wins over en_i)
//   tc_o   out  terminal count: en_i is high and count == STEP_DIV-1
// -----------------------------------------------------------------------------
module gray_paso_timer #(
    parameter int unsigned STEP_DIV = 5
) (
    input  logic reloj,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    // A one-bit counter is kept even for STEP_DIV == 1 so the vector is never
    // zero width; in that case the terminal count fires on every enabled cycle.
    localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(STEP_DIV - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign tc_o = en_i && (timer_q == LAST);

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // left one unassigned would infer a latch.
        timer_d = timer_q;
        if (clr_i) begin
            timer_d = '0;
        end else if (en_i) begin
            timer_d = tc_o ? '0 : timer_q + TW'(1);
        end
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule : gray_paso_timer

// File: rtl/gray_emisor.sv
// -----------------------------------------------------------------------------
// gray_emisor
//
// Gray-code transmitter. Holds a binary count, encodes it to Gray and
// presents each word on a registered bus with a valid/ack handshake. Words
// come from an explicit binary load (modo=0) or from an auto-stepping
// up/down counter (modo=1) that advances after STEP_DIV idle cycles.
//
// Ports:
//   reloj     in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   modo      in   0 = load mode, 1 = auto-count mode
//   load      in   load request (ignored in auto mode)
//   bin_in    in   binary value captured on an accepted load
//   dir       in   auto-count direction: 1 = up, 0 = down
//   ack       in   reader acknowledge (ignored while valid is low)
//   gray_out  out  registered Gray word, encoded from the internal count
//   valid     out  gray_out holds an unacknowledged word
//   overrun   out  sticky: a load arrived while a word was still pending
// -----------------------------------------------------------------------------
module gray_emisor
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = GRAY_WIDTH,
    parameter int unsigned STEP_DIV = 5
) (
    input  logic             reloj,
    input  logic             rst_n,
    input  logic             modo,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             dir,
    input  logic             ack,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             overrun
);

    // Narrow wrapper around the shared encoder.
    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] b);
        logic [GRAY_MAX_W-1:0] wide;
        wide = bin2gray(GRAY_MAX_W'(b));
        return wide[WIDTH-1:0];
    endfunction

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] gray_q,    gray_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    logic             timer_en;
    logic             step_tc;
    logic             load_req;
    logic [WIDTH-1:0] cnt_step;

    // The timer only runs while waiting in auto mode. Leaving WAIT because
    // modo dropped clears it on that same edge, so a later return to auto
    // mode always starts a full STEP_DIV interval.
    assign timer_en = (state_q == WAIT) && modo;

    gray_paso_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .reloj (reloj),
        .rst_n (rst_n),
        .en_i  (timer_en),
        .clr_i (!timer_en),
        .tc_o  (step_tc)
    );

    // Loads are only honoured in load mode.
    assign load_req = !modo && load;

    // Modulo-2^WIDTH step; dir is sampled on the stepping edge itself.
    assign cnt_step = dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gray_d    = gray_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (modo) begin
                    state_d = WAIT;
                end else if (load) begin
                    cnt_d   = bin_in;
                    gray_d  = enc(bin_in);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end

            WAIT: begin
                // Leaving auto mode wins over a coincident step.
                if (!modo) begin
                    state_d = IDLE;
                end else if (step_tc) begin
                    cnt_d   = cnt_step;
                    gray_d  = enc(cnt_step);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end

            PRESENT: begin
                if (ack) begin
                    if (load_req) begin
                        // Word completed and replaced on the same edge:
                        // valid never drops.
                        cnt_d  = bin_in;
                        gray_d = enc(bin_in);
                    end else begin
                        valid_d = 1'b0;
                        state_d = modo ? WAIT : IDLE;
                    end
                end else if (load_req) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gray_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gray_q    <= gray_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign gray_out = gray_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;

endmodule : gray_emisor

// File: tb/tb_gray_emisor.sv
// -----------------------------------------------------------------------------
// tb_gray_emisor
//
// Self-checking bench for gray_emisor (WIDTH=4, STEP_DIV=5). A behavioural
// model tracks the binary value on the bus, whether a word is pending, how
// many cycles the auto stepper has waited and the sticky overrun flag; a
// compare process checks the DUT against it on every falling edge. Directed
// scenarios pin the model with hand-computed Gray words, then a randomized
// phase exercises mode changes, loads, acks and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_gray_emisor;

    localparam int W  = 4;
    localparam int SD = 5;
    localparam int M  = 2 ** W;

    logic         reloj  = 1'b0;
    logic         rst_n  = 1'b1;
    logic         modo   = 1'b0;
    logic         load   = 1'b0;
    logic [W-1:0] bin_in = '0;
    logic         dir    = 1'b1;
    logic         ack    = 1'b0;
    logic [W-1:0] gray_out;
    logic         valid;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    gray_emisor #(
        .WIDTH    (W),
        .STEP_DIV (SD)
    ) dut (
        .reloj    (reloj),
        .rst_n    (rst_n),
        .modo     (modo),
        .load     (load),
        .bin_in   (bin_in),
        .dir      (dir),
        .ack      (ack),
        .gray_out (gray_out),
        .valid    (valid),
        .overrun  (overrun)
    );

    always #5 reloj = ~reloj;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gray_of(input int v);
        int g;
        g = (v ^ (v >> 1)) % M;
        return g[W-1:0];
    endfunction

    // ---------------- behavioural model ----------------
    int m_cnt     = 0;  // binary value currently (or last) on the bus
    bit m_valid   = 0;  // a word is pending
    bit m_ovr     = 0;
    bit m_waiting = 0;  // auto mode, counting idle cycles
    int m_ticks   = 0;  // idle cycles already waited

    always @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_valid   <= 0;
            m_ovr     <= 0;
            m_waiting <= 0;
            m_ticks   <= 0;
        end else if (m_valid) begin
            if (ack && !modo && load) begin
                m_cnt <= int'(bin_in);
            end else if (ack) begin
                m_valid   <= 0;
                m_waiting <= modo;
                m_ticks   <= 0;
            end else if (!modo && load) begin
                m_ovr <= 1;
            end
        end else if (m_waiting) begin
            if (!modo) begin
                m_waiting <= 0;
                m_ticks   <= 0;
            end else if (m_ticks + 1 == SD) begin
                m_cnt     <= (m_cnt + (dir ? 1 : M - 1)) % M;
                m_valid   <= 1;
                m_waiting <= 0;
                m_ticks   <= 0;
            end else begin
                m_ticks <= m_ticks + 1;
            end
        end else if (modo) begin
            m_waiting <= 1;
            m_ticks   <= 0;
        end else if (load) begin
            m_cnt   <= int'(bin_in);
            m_valid <= 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge reloj) begin
        check("model_gray_out", gray_out, gray_of(m_cnt));
        check("model_valid", valid, m_valid);
        check("model_overrun", overrun, m_ovr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (valid !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (valid !== 1'b1) check("valid_timeout", valid, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [W-1:0] prev;
        logic [W-1:0] held;

        #1;
        do_reset();
        check("reset_gray", gray_out, 4'b0000);
        check("reset_valid", valid, 1'b0);
        check("reset_overrun", overrun, 1'b0);

        // Load mode: 11 -> 1110 on the load edge, ack one cycle later.
        modo = 1'b0; bin_in = 4'd11; load = 1'b1;
        step();
        check("load11_gray", gray_out, 4'b1110);
        check("load11_valid", valid, 1'b1);
        load = 1'b0;
        step();
        ack = 1'b1;
        step();
        check("ack_valid", valid, 1'b0);
        check("ack_gray_hold", gray_out, 4'b1110);
        ack = 1'b0;

        // Overrun, then same-edge ack + load.
        bin_in = 4'd4; load = 1'b1;
        step();
        bin_in = 4'd3;
        step();
        check("ovr_gray", gray_out, 4'b0110);
        check("ovr_flag", overrun, 1'b1);
        bin_in = 4'd5; ack = 1'b1;
        step();
        check("simul_valid", valid, 1'b1);
        check("simul_gray", gray_out, 4'b0111);
        load = 1'b0;
        step();
        ack = 1'b0;

        // Async reset mid-PRESENT, observed before the next edge.
        bin_in = 4'd4; load = 1'b1;
        step();
        load = 1'b0;
        check("pre_rst_gray", gray_out, 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gray", gray_out, 4'b0000);
        check("async_rst_valid", valid, 1'b0);
        check("async_rst_overrun", overrun, 1'b0);
        step();
        rst_n = 1'b1;

        // Auto up with ack tied high: full cycle including wrap.
        modo = 1'b1; dir = 1'b1; ack = 1'b1;
        prev = gray_out;
        for (int i = 1; i <= M; i++) begin
            if (i > 1) begin
                step();
                check("auto_ack_drop", valid, 1'b0);
            end
            wait_valid(50, n);
            if (i > 1) check("auto_spacing", n + 1, SD + 1);
            check("auto_up_word", gray_out, gray_of(i % M));
            check("auto_one_bit", $countones(gray_out ^ prev), 1);
            prev = gray_out;
        end
        modo = 1'b0;
        step();

        // Auto down from reset, then direction flipped while waiting.
        do_reset();
        modo = 1'b1; dir = 1'b0; ack = 1'b1;
        wait_valid(50, n);
        check("down_first", gray_out, 4'b1000);
        step();
        wait_valid(50, n);
        check("down_second", gray_out, 4'b1001);
        step();
        step();
        dir = 1'b1;
        wait_valid(50, n);
        check("dir_flip", gray_out, 4'b1000);

        // Back-pressure: ack held low, loads ignored in auto mode.
        ack = 1'b0; load = 1'b1; bin_in = 4'd9;
        held = gray_out;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_gray_stable", gray_out, held);
            check("bp_valid_stable", valid, 1'b1);
        end
        check("bp_no_overrun", overrun, 1'b0);
        load = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        check("bp_ack_drop", valid, 1'b0);
        wait_valid(50, n);
        check("bp_next_delay", n, SD);
        check("bp_next_word", gray_out, 4'b0000);

        // Randomized phase; the compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) modo = ~modo;
            load   = ($urandom_range(0, 2) == 0);
            ack    = ($urandom_range(0, 1) == 0);
            dir    = $urandom_range(0, 1) == 1;
            bin_in = W'($urandom_range(0, M - 1));
            step();
        end

        @(negedge reloj);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gray_emisor
